// File: rtl/wallace_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined Wallace-tree
// multiplier.
//   WIDTH_DEF / STAGES_DEF / TAG_W_DEF : default parameter values
//   pp_per_col   : partial-product bits landing in a given product column
//   rows_next    : rows left after one level of 3:2 compression
//   rows_at      : rows present after a given number of tree levels
//   tree_levels  : compression levels needed to reach two rows
//   stage_pos    : tree level at which pipeline register j sits
//   last_reg_at  : highest-numbered register sitting at a level (-1 if none)
package wallace_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int STAGES_DEF = 2;
  localparam int TAG_W_DEF  = 4;

  // Rows are sign-extended to full product width, so row i feeds every column
  // from i upward; column 0 also carries the +1 of the two's-complement
  // negation used for a signed multiplier's top bit.
  function automatic int pp_per_col(input int width, input int col);
    int n;
    n = (col + 1 < width) ? col + 1 : width;
    if (col == 0) n = n + 1;
    return n;
  endfunction

  function automatic int rows_next(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int rows_at(input int n0, input int lvl);
    int n;
    n = n0;
    for (int i = 0; i < lvl; i++) n = rows_next(n);
    return n;
  endfunction

  function automatic int tree_levels(input int n0);
    int n;
    int l;
    n = n0;
    l = 0;
    while (n > 2) begin
      n = rows_next(n);
      l = l + 1;
    end
    return l;
  endfunction

  // Registers are spread evenly over the tree; the last one always sits after
  // the final level so the carry-propagate adder lives in the output stage.
  function automatic int stage_pos(input int j, input int levels, input int stages);
    return ((j + 1) * levels) / stages;
  endfunction

  function automatic int last_reg_at(input int k, input int levels, input int stages);
    int r;
    r = -1;
    for (int j = 0; j < stages; j++)
      if (stage_pos(j, levels, stages) == k) r = j;
    return r;
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// Bit-vector 3:2 carry-save compressor: x + y + z == s + c (mod 2^N).
//   x, y, z : input rows
//   s       : bitwise sum row
//   c       : carry row, already shifted up one column
module csa_3to2 #(
  parameter int N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] s,
  output logic [N-1:0] c
);

  assign s = x ^ y ^ z;
  // The carry out of the top column falls off: all rows are modulo 2^N.
  assign c = ((x & y) | (x & z) | (y & z)) << 1;

endmodule

// File: rtl/wallace_tree_mult_pipe.sv
// Pipelined Wallace-tree multiplier with valid/ready handshake and a user tag.
// Signedness of each operand is folded into the partial-product rows, so the
// rows themselves carry it through the pipeline alongside the tag.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready is the advance enable)
//   a, b                : operands, a_signed / b_signed select two's complement
//   in_tag              : opaque tag returned with the product
//   out_valid/out_ready : product handshake
//   z, out_tag          : 2*WIDTH-bit product and its tag (zero when not valid)
module wallace_tree_mult_pipe
  import wallace_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 a_signed,
  input  logic                 b_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   z,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int W2     = 2 * WIDTH;
  // Tallest column plus the negation correction row.
  localparam int NROWS  = pp_per_col(WIDTH, W2 - 1) + 1;
  localparam int LEVELS = tree_levels(NROWS);

  logic adv;
  logic [W2-1:0] a_ext;
  logic [NROWS-1:0][W2-1:0] pp;
  logic [W2-1:0] sum;

  // A signed multiplier's top bit weighs -2^(WIDTH-1): that row is negated as
  // ~row plus a 1 in column 0 (the extra row).
  always_comb begin
    a_ext = a_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    pp = '0;
    for (int i = 0; i < WIDTH - 1; i++)
      pp[i] = b[i] ? (a_ext << i) : '0;
    if (b[WIDTH-1])
      pp[WIDTH-1] = b_signed ? ~(a_ext << (WIDTH - 1)) : (a_ext << (WIDTH - 1));
    pp[WIDTH][0] = b_signed & b[WIDTH-1];
  end

  // Stall depends only on the output stage; bubbles inside are not squeezed.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar j = 0; j < STAGES; j++) begin : g_st
    localparam int P  = stage_pos(j, LEVELS, STAGES);
    localparam int NR = rows_at(NROWS, P);

    logic                 v;
    logic                 v_d;
    logic [TAG_W-1:0]     t;
    logic [TAG_W-1:0]     t_d;
    logic [NR-1:0][W2-1:0] q;
    logic [NR-1:0][W2-1:0] d;

    if (j == 0) begin : g_ctl_first
      assign v_d = in_valid;
      assign t_d = in_tag;
    end else begin : g_ctl_next
      assign v_d = g_st[j-1].v;
      assign t_d = g_st[j-1].t;
    end

    // Several registers can land on the same tree level when STAGES exceeds
    // the level count; those simply chain.
    if (j > 0 && stage_pos(j - 1, LEVELS, STAGES) == P) begin : g_d_chain
      assign d = g_st[j-1].q;
    end else if (P == 0) begin : g_d_pp
      assign d = pp;
    end else begin : g_d_tree
      assign d = g_lvl[P-1].dout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) v <= 1'b0;
      else if (adv) v <= v_d;
    end

    always_ff @(posedge clk) begin
      if (adv) begin
        q <= d;
        t <= t_d;
      end
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NI = rows_at(NROWS, l);
    localparam int NO = rows_at(NROWS, l + 1);
    localparam int G  = NI / 3;
    localparam int LR = last_reg_at(l, LEVELS, STAGES);

    logic [NI-1:0][W2-1:0] din;
    logic [NO-1:0][W2-1:0] dout;

    if (LR >= 0) begin : g_in_reg
      assign din = g_st[LR].q;
    end else if (l == 0) begin : g_in_pp
      assign din = pp;
    end else begin : g_in_lvl
      assign din = g_lvl[l-1].dout;
    end

    for (genvar k = 0; k < G; k++) begin : g_csa
      csa_3to2 #(.N(W2)) u_csa (
        .x (din[3*k]),
        .y (din[3*k+1]),
        .z (din[3*k+2]),
        .s (dout[2*k]),
        .c (dout[2*k+1])
      );
    end

    // Rows left over from the groups of three drop straight to the next level.
    for (genvar r = 3 * G; r < NI; r++) begin : g_pass
      assign dout[2*G + r - 3*G] = din[r];
    end
  end

  assign sum       = g_st[STAGES-1].q[0] + g_st[STAGES-1].q[1];
  assign out_valid = g_st[STAGES-1].v;
  assign z         = out_valid ? sum : '0;
  assign out_tag   = out_valid ? g_st[STAGES-1].t : '0;

endmodule

// File: tb/tb_wallace_tree_mult_pipe.sv
module tb_wallace_tree_mult_pipe;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            a_signed;
  logic            b_signed;
  logic [TW-1:0]   in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  z;
  logic [TW-1:0]   out_tag;

  wallace_tree_mult_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .a_signed  (a_signed),
    .b_signed  (b_signed),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pops = 0;
  int gaps = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  bit gap_en = 0;
  bit seen = 0;
  logic [TW+2*W-1:0] sb_q[$];
  logic [TW+2*W-1:0] exp_e;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  function automatic void fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endfunction

  // Reference: plain integer product of the two interpreted operands.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic xs, input logic ys);
    longint vx;
    longint vy;
    longint p;
    vx = xs ? longint'($signed(x)) : longint'(x);
    vy = ys ? longint'($signed(y)) : longint'(y);
    p = vx * vy;
    return p[2*W-1:0];
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: handshakes seen at the falling edge complete at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        pops++;
        if (gap_en) begin
          if (seen && cyc != last_pop_cyc + 1) gaps++;
          seen = 1;
          last_pop_cyc = cyc;
        end else begin
          seen = 0;
        end
        if (sb_q.size() == 0) begin
          check("spurious_out", {63'd0, out_valid}, 64'd0);
        end else begin
          exp_e = sb_q.pop_front();
          check("z", {48'd0, z}, {48'd0, exp_e[2*W-1:0]});
          check("tag", {60'd0, out_tag}, {60'd0, exp_e[TW+2*W-1:2*W]});
        end
      end
      if (in_valid && in_ready)
        sb_q.push_back({in_tag, model(a, b, a_signed, b_signed)});
    end
  end

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic as_,
                      input logic bs_, input logic [TW-1:0] tg, output int ncyc);
    bit ok;
    a = av; b = bv; a_signed = as_; b_signed = bs_; in_tag = tg;
    in_valid = 1'b1;
    ncyc = 0;
    ok = 0;
    while (!ok && ncyc < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      ncyc++;
    end
    #1 in_valid = 1'b0;
    if (!ok) fail_now("send_timeout");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic lat_check(input logic [W-1:0] av, input logic [W-1:0] bv, input logic as_,
                           input logic bs_, input logic [TW-1:0] tg, input logic [2*W-1:0] zexp,
                           input string name);
    int n;
    send(av, bv, as_, bs_, tg, n);
    check({name, "_early"}, {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    check({name, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({name, "_z"}, {48'd0, z}, {48'd0, zexp});
    check({name, "_tag"}, {60'd0, out_tag}, {60'd0, tg});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int tot;
    int p0;
    bit acc;
    logic [W-1:0] corners [6];
    logic [W-1:0] s1a;
    logic [W-1:0] s1b;

    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0; in_tag = '0;
    #3;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_z", {48'd0, z}, 64'd0);
    check("rst_tag", {60'd0, out_tag}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    lat_check(8'h80, 8'h80, 1'b1, 1'b1, 4'd3, 16'h4000, "neg_sq");
    lat_check(8'hFF, 8'hFF, 1'b0, 1'b0, 4'd1, 16'hFE01, "ff_uu");
    lat_check(8'hFF, 8'hFF, 1'b1, 1'b0, 4'd2, 16'hFF01, "ff_su");
    drain();

    // Back-to-back stream.
    gap_en = 1;
    p0 = pops;
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 4'(i), n);
      tot += n;
    end
    drain();
    check("stream_in_cycles", tot, 16);
    check("stream_count", pops - p0, 16);
    check("stream_gaps", gaps, 0);
    gap_en = 0;

    // Output stall with the pipeline full.
    out_ready = 1'b0;
    p0 = pops;
    s1a = 8'($urandom);
    s1b = 8'($urandom);
    send(s1a, s1b, 1'b1, 1'b0, 4'hA, n);
    send(8'($urandom), 8'($urandom), 1'b0, 1'b1, 4'hB, n);
    fork
      send(8'($urandom), 8'($urandom), 1'b1, 1'b1, 4'hC, n);
      begin
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", {63'd0, in_ready}, 64'd0);
          check("stall_valid", {63'd0, out_valid}, 64'd1);
          check("stall_z", {48'd0, z}, {48'd0, model(s1a, s1b, 1'b1, 1'b0)});
          check("stall_tag", {60'd0, out_tag}, 64'hA);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_count", pops - p0, 3);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(8'($urandom), 8'($urandom), 1'b0, 1'b0, 4'h6, n);
    send(8'($urandom), 8'($urandom), 1'b0, 1'b0, 4'h7, n);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_z", {48'd0, z}, 64'd0);
    check("mid_rst_tag", {60'd0, out_tag}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_stale", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    lat_check(8'h07, 8'hFD, 1'b1, 1'b1, 4'h5, 16'hFFEB, "post_rst");
    drain();

    // Corner operands under every flag combination.
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        for (int f = 0; f < 4; f++)
          send(corners[i], corners[j], f[1], f[0], 4'(i + j + f), n);
    drain();

    // Random operands with random handshake pressure on both sides.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = 8'($urandom);
        b = 8'($urandom);
        a_signed = 1'($urandom);
        b_signed = 1'($urandom);
        in_tag = 4'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
